mbus_write_arbiter: RTL and testbench

- Shares the single DDR write controller port among DEVICE_NUM frame-write requesters (video channels 0..3).
- Picks one requester by round-robin and drives the one-hot o_mbus_wsel back to the requesters.
- Forwards the winner's address, data and ready to the controller, and holds the grant until the controller's busy completes.
- Sits between the per-channel frame-write interfaces and the DDR write controller, in the i_axi_aclk domain.

---
 rtl/mbus_write_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mbus_write_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbus_write_arbiter.sv
// Purpose : round-robin arbiter sharing one DDR write-controller port among DEVICE_NUM frame writers.
// Latency : wrq -> o_mbus_wsel 1 cycle; o_ctrl_wrq pulses the cycle wsel rises; grant held until busy falls.
// Backpressure: a grant is held until the controller's busy completes; other requesters wait (level wrq).
//
// Ports:
//   i_axi_aclk / i_rst        clock, asynchronous active-high reset
//   i_mbus_wrq/waddr/wdata/wready   per-requester level request, packed address, packed data, ready
//   o_mbus_wsel               one-hot grant back to requesters
//   o_ctrl_wrq/waddr/wdata/wready   request pulse, latched address, muxed data/ready to the controller
//   i_ctrl_wbusy              controller busy (burst in progress)
//   o_grant_id                index of current or last winner
//   o_timeout                 abort pulse when busy never rose after a request
// Optional: define MBUS_ARB_ACK_TIMEOUT_EN to abort a grant whose busy does not rise within ACK_TIMEOUT cycles.

module mbus_write_arbiter #(
    parameter int MEM_DQ_WIDTH    = 16,
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int BURST_LENGTH    = 8,
    parameter int DEVICE_NUM      = 4,
    parameter int ACK_TIMEOUT     = 255
) (
    input  logic                                        i_axi_aclk,
    input  logic                                        i_rst,
    input  logic [DEVICE_NUM-1:0]                       i_mbus_wrq,
    input  logic [DEVICE_NUM*CTRL_ADDR_WIDTH-1:0]       i_mbus_waddr,
    input  logic [DEVICE_NUM*MEM_DQ_WIDTH*BURST_LENGTH-1:0] i_mbus_wdata,
    input  logic [DEVICE_NUM-1:0]                       i_mbus_wready,
    output logic [DEVICE_NUM-1:0]                       o_mbus_wsel,
    output logic                                        o_ctrl_wrq,
    output logic [CTRL_ADDR_WIDTH-1:0]                  o_ctrl_waddr,
    output logic [MEM_DQ_WIDTH*BURST_LENGTH-1:0]        o_ctrl_wdata,
    output logic                                        o_ctrl_wready,
    input  logic                                        i_ctrl_wbusy,
    output logic [2:0]                                  o_grant_id,
    output logic                                        o_timeout
);

    localparam int DW  = MEM_DQ_WIDTH * BURST_LENGTH;
    localparam int CAW = CTRL_ADDR_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_BUSY, S_GAP} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              ptr;
    logic                    latch_grant;
    logic                    release_grant;

    // Round-robin pick: rotate the request vector so bit 0 is (ptr+1),
    // take the lowest set bit, then rotate the offset back.
    logic [2:0]              start;
    logic [DEVICE_NUM-1:0]   rot;
    int                      off;
    int                      sum;
    logic [2:0]              pick_id;
    logic [DEVICE_NUM-1:0]   pick_oh;
    logic [CAW-1:0]          pick_addr;

    always_comb begin
        start = (ptr >= 3'(DEVICE_NUM-1)) ? 3'd0 : ptr + 3'd1;
        rot   = DEVICE_NUM'({i_mbus_wrq, i_mbus_wrq} >> start);
        off   = 0;
        for (int j = DEVICE_NUM-1; j >= 0; j--) begin
            if (rot[j]) off = j;
        end
        sum = int'(start) + off;
        if (sum >= DEVICE_NUM) sum = sum - DEVICE_NUM;
        pick_id = 3'(sum);
        pick_oh = DEVICE_NUM'(1) << pick_id;
        pick_addr = '0;
        for (int k = 0; k < DEVICE_NUM; k++) begin
            if (pick_oh[k]) pick_addr = pick_addr | i_mbus_waddr[k*CAW +: CAW];
        end
    end

`ifdef MBUS_ARB_ACK_TIMEOUT_EN
    localparam int TW_RAW = $clog2(ACK_TIMEOUT + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : TW_RAW;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
`endif

    // State register
    always_ff @(posedge i_axi_aclk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt     = state;
        latch_grant   = 1'b0;
        release_grant = 1'b0;
`ifdef MBUS_ARB_ACK_TIMEOUT_EN
        tmo_hit       = 1'b0;
`endif
        case (state)
            S_IDLE: if (|i_mbus_wrq) begin
                latch_grant = 1'b1;
                state_nxt   = S_REQ;
            end
            S_REQ:  state_nxt = S_WAIT;
            // A busy already high here (left over from a previous burst) counts as the ack.
            S_WAIT: begin
                if (i_ctrl_wbusy) begin
                    state_nxt = S_BUSY;
                end
`ifdef MBUS_ARB_ACK_TIMEOUT_EN
                else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    tmo_hit       = 1'b1;
                    release_grant = 1'b1;
                    state_nxt     = S_GAP;
                end
`endif
            end
            S_BUSY: if (!i_ctrl_wbusy) begin
                release_grant = 1'b1;
                state_nxt     = S_GAP;
            end
            // One dead cycle so the released requester can drop wrq before re-arbitration.
            S_GAP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: request pulse and data mux follow the grant combinationally.
    always_comb begin
        o_ctrl_wrq    = (state == S_REQ);
        o_ctrl_wdata  = '0;
        o_ctrl_wready = 1'b0;
        for (int k = 0; k < DEVICE_NUM; k++) begin
            if (o_mbus_wsel[k]) begin
                o_ctrl_wdata  = o_ctrl_wdata | i_mbus_wdata[k*DW +: DW];
                o_ctrl_wready = o_ctrl_wready | i_mbus_wready[k];
            end
        end
    end

    // Grant registers: address is captured only at arbitration time.
    always_ff @(posedge i_axi_aclk or posedge i_rst) begin
        if (i_rst) begin
            o_mbus_wsel  <= '0;
            o_grant_id   <= 3'(DEVICE_NUM-1);
            o_ctrl_waddr <= '0;
            ptr          <= 3'(DEVICE_NUM-1);
        end else if (latch_grant) begin
            o_mbus_wsel  <= pick_oh;
            o_grant_id   <= pick_id;
            o_ctrl_waddr <= pick_addr;
        end else if (release_grant) begin
            o_mbus_wsel  <= '0;
            ptr          <= o_grant_id;
        end
    end

`ifdef MBUS_ARB_ACK_TIMEOUT_EN
    always_ff @(posedge i_axi_aclk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt   <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= tmo_hit;
            if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
            else                 tmo_cnt <= '0;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mbus_write_arbiter.sv
// Purpose : directed vector bench for mbus_write_arbiter (4 devices, 128-bit data).
// Latency : outputs sampled 1 time unit after each rising clock edge.
// Backpressure: controller busy is driven by the bench; every wait is cycle-bounded.
module tb_mbus_write_arbiter;

    localparam int DN  = 4;
    localparam int CAW = 28;
    localparam int DW  = 128;

    localparam logic [CAW-1:0] A0 = 28'h0000000;
    localparam logic [CAW-1:0] A1 = 28'h0001000;
    localparam logic [CAW-1:0] A2 = 28'h00FD200;
    localparam logic [CAW-1:0] A3 = 28'h0ABC000;
    localparam logic [DW-1:0]  D0 = {16{8'h3C}};
    localparam logic [DW-1:0]  D1 = {16{8'hA5}};
    localparam logic [DW-1:0]  D2 = {16{8'h5A}};
    localparam logic [DW-1:0]  D3 = {16{8'hC3}};

    logic              clk = 1'b0;
    logic              rst;
    logic [DN-1:0]     wrq;
    logic [DN*CAW-1:0] waddr;
    logic [DN*DW-1:0]  wdata;
    logic [DN-1:0]     wready;
    logic [DN-1:0]     wsel;
    logic              ctrl_wrq;
    logic [CAW-1:0]    ctrl_waddr;
    logic [DW-1:0]     ctrl_wdata;
    logic              ctrl_wready;
    logic              busy;
    logic [2:0]        gid;
    logic              timeout;

    always #5 clk = ~clk;

    mbus_write_arbiter dut (
        .i_axi_aclk   (clk),
        .i_rst        (rst),
        .i_mbus_wrq   (wrq),
        .i_mbus_waddr (waddr),
        .i_mbus_wdata (wdata),
        .i_mbus_wready(wready),
        .o_mbus_wsel  (wsel),
        .o_ctrl_wrq   (ctrl_wrq),
        .o_ctrl_waddr (ctrl_waddr),
        .o_ctrl_wdata (ctrl_wdata),
        .o_ctrl_wready(ctrl_wready),
        .i_ctrl_wbusy (busy),
        .o_grant_id   (gid),
        .o_timeout    (timeout)
    );

    int n_vec = 0;
    int n_bad = 0;
    int multi_hot = 0;

    always @(negedge clk) if (!$onehot0(wsel)) multi_hot++;

    task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_req(input string nm);
        bit seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (ctrl_wrq) seen = 1;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no o_ctrl_wrq within 20 cycles", nm);
        end
    endtask

    task automatic wait_release(input string nm);
        bit seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (wsel == '0) seen = 1;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: wsel not released within 20 cycles", nm);
        end
    endtask

    typedef struct {
        logic [3:0]     wrq;
        logic           busy;
        logic [3:0]     wsel;
        logic           cwrq;
        logic [2:0]     gid;
        logic [CAW-1:0] addr;
        logic           wready;
        logic [DW-1:0]  wdata;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] w, input logic b, input logic [3:0] s,
                                input logic c, input logic [2:0] g, input logic [CAW-1:0] a,
                                input logic r, input logic [DW-1:0] d);
        vec_t v;
        v.wrq = w; v.busy = b; v.wsel = s; v.cwrq = c;
        v.gid = g; v.addr = a; v.wready = r; v.wdata = d;
        return v;
    endfunction

    vec_t vt[16];
    logic [3:0] one = 4'b0001;
    int exp_id[5] = '{0, 1, 2, 3, 0};
    int n_edges;

    initial begin
        // Device 2 alone, then device 1 (the only ready device), then device 1 again with stale busy.
        vt[0]  = mk(4'b0100, 1'b0, 4'b0100, 1'b1, 3'd2, A2, 1'b0, D2);
        vt[1]  = mk(4'b0100, 1'b0, 4'b0100, 1'b0, 3'd2, A2, 1'b0, D2);
        vt[2]  = mk(4'b0100, 1'b1, 4'b0100, 1'b0, 3'd2, A2, 1'b0, D2);
        vt[3]  = mk(4'b0100, 1'b1, 4'b0100, 1'b0, 3'd2, A2, 1'b0, D2);
        vt[4]  = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd2, A2, 1'b0, '0);
        vt[5]  = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd2, A2, 1'b0, '0);
        vt[6]  = mk(4'b0010, 1'b0, 4'b0010, 1'b1, 3'd1, A1, 1'b1, D1);
        vt[7]  = mk(4'b0010, 1'b0, 4'b0010, 1'b0, 3'd1, A1, 1'b1, D1);
        vt[8]  = mk(4'b0010, 1'b1, 4'b0010, 1'b0, 3'd1, A1, 1'b1, D1);
        vt[9]  = mk(4'b0010, 1'b0, 4'b0000, 1'b0, 3'd1, A1, 1'b0, '0);
        vt[10] = mk(4'b0010, 1'b0, 4'b0000, 1'b0, 3'd1, A1, 1'b0, '0);
        vt[11] = mk(4'b0010, 1'b1, 4'b0010, 1'b1, 3'd1, A1, 1'b1, D1);
        vt[12] = mk(4'b0010, 1'b1, 4'b0010, 1'b0, 3'd1, A1, 1'b1, D1);
        vt[13] = mk(4'b0010, 1'b1, 4'b0010, 1'b0, 3'd1, A1, 1'b1, D1);
        vt[14] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd1, A1, 1'b0, '0);
        vt[15] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd1, A1, 1'b0, '0);

        rst    = 1'b1;
        wrq    = '0;
        busy   = 1'b0;
        wready = 4'b0010;
        waddr  = {A3, A2, A1, A0};
        wdata  = {D3, D2, D1, D0};
        #1;
        chk("reset_state", {wsel, ctrl_wrq, ctrl_waddr, gid, timeout, ctrl_wready, ctrl_wdata},
            {4'b0000, 1'b0, 28'h0, 3'd3, 1'b0, 1'b0, 128'h0});
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wrq  = vt[i].wrq;
            busy = vt[i].busy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i),
                {wsel, ctrl_wrq, gid, ctrl_waddr, ctrl_wready, ctrl_wdata},
                {vt[i].wsel, vt[i].cwrq, vt[i].gid, vt[i].addr, vt[i].wready, vt[i].wdata});
        end

        // All requesters active after reset: strict rotation 0,1,2,3,0 with 10+ cycles of busy.
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        wrq = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_req("rot_req");
            chk($sformatf("rot_grant%0d", g), {wsel, gid}, {one << exp_id[g], 3'(exp_id[g])});
            busy = 1'b1;
            repeat (11) @(posedge clk);
            #1 busy = 1'b0;
            wait_release("rot_release");
        end
        chk("wsel_never_multihot", 168'(multi_hot), 168'(0));

        // Device 3 granted (pointer at 0), reset dropped in during BUSY.
        wrq = 4'b1000;
        wait_req("rst_req");
        chk("rst_grant3", {wsel, gid, ctrl_waddr}, {4'b1000, 3'd3, A3});
        busy = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {wsel, ctrl_wrq, ctrl_waddr, gid}, {4'b0000, 1'b0, 28'h0, 3'd3});
        @(negedge clk);
        rst  = 1'b0;
        busy = 1'b0;
        wrq  = 4'b1111;
        wait_req("post_rst_req");
        chk("post_reset_first", {wsel, gid}, {4'b0001, 3'd0});

        // Device 0 address changes mid-grant: latched value must hold until the next grant.
        busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 waddr[0 +: CAW] = 28'h0000400;
        repeat (2) @(posedge clk);
        #1;
        chk("addr_held", 168'(ctrl_waddr), 168'(A0));
        busy = 1'b0;
        wrq  = 4'b0001;
        wait_req("addr_req");
        chk("addr_next_grant", {gid, ctrl_waddr}, {3'd0, 28'h0000400});

`ifdef MBUS_ARB_ACK_TIMEOUT_EN
        // Busy never rises: abort 255 cycles after WAIT entry, then rotate past device 0.
        n_edges = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            n_edges++;
            if (timeout) break;
        end
        chk("timeout_cycle", {timeout, 32'(n_edges)}, {1'b1, 32'd256});
        chk("timeout_release", 168'(wsel), 168'(0));
        wrq = 4'b1111;
        wait_req("tmo_req");
        chk("timeout_next", 168'(gid), 168'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
